// File: rtl/core_wb_stage_if.sv
// core_wb_stage_if: MEM-side handshake, dmem response and regfile write port of the writeback stage
interface core_wb_stage_if #(
  parameter int XLEN      = 32,
  parameter int RET_CNT_W = 32
);
  logic                 mem_valid;
  logic                 mem_ready;
  logic [4:0]           mem_rd_addr;
  logic                 mem_rd_wen;
  logic                 mem_is_load;
  logic [2:0]           mem_funct3;
  logic [1:0]           mem_addr_lo;
  logic [XLEN-1:0]      mem_result;
  logic                 dmem_rvalid;
  logic [XLEN-1:0]      dmem_rdata;
  logic [4:0]           reg_waddr;
  logic [XLEN-1:0]      reg_wdata;
  logic                 reg_wen;
  logic                 load_err;
  logic [RET_CNT_W-1:0] instret;
  modport master (
    output mem_valid, mem_rd_addr, mem_rd_wen, mem_is_load, mem_funct3, mem_addr_lo,
           mem_result, dmem_rvalid, dmem_rdata,
    input  mem_ready, reg_waddr, reg_wdata, reg_wen, load_err, instret
  );
  modport slave (
    input  mem_valid, mem_rd_addr, mem_rd_wen, mem_is_load, mem_funct3, mem_addr_lo,
           mem_result, dmem_rvalid, dmem_rdata,
    output mem_ready, reg_waddr, reg_wdata, reg_wen, load_err, instret
  );
endinterface

// File: rtl/core_wb_stage.sv
// core_wb_stage: writeback stage; registers one regfile write per retiring op,
// waits for dmem on loads and extracts/extends the addressed byte, half or word.
module core_wb_stage #(
  parameter int XLEN      = 32,
  parameter int RET_CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst_sync,
  input  logic           stall_n,
  core_wb_stage_if.slave wb
);
  typedef enum logic {IDLE, WAIT_LOAD} state_t;
  state_t               state_q;
  logic [4:0]           rd_q;
  logic [2:0]           f3_q;
  logic [1:0]           lo_q;
  logic [4:0]           reg_waddr_q;
  logic [XLEN-1:0]      reg_wdata_q;
  logic                 reg_wen_q;
  logic                 load_err_q;
  logic [RET_CNT_W-1:0] instret_q;
  logic [7:0]           byte_d;
  logic [15:0]          half_d;
  logic [XLEN-1:0]      ld_data_d;
  logic                 bad_load_d;
  always_comb begin
    byte_d     = wb.dmem_rdata[{lo_q, 3'b000} +: 8];
    half_d     = wb.dmem_rdata[{lo_q[1], 4'b0000} +: 16];
    ld_data_d  = f3_q[1:0] == 2'd0 ? {{(XLEN-8){byte_d[7] & ~f3_q[2]}}, byte_d}
               : f3_q[1:0] == 2'd1 ? {{(XLEN-16){half_d[15] & ~f3_q[2]}}, half_d}
               : wb.dmem_rdata;
    // funct3 3/6/7 are illegal; LH/LHU need even, LW word-aligned addresses
    bad_load_d = wb.mem_funct3 == 3'd3 || wb.mem_funct3[2:1] == 2'b11
              || (wb.mem_funct3[1:0] == 2'd1 && wb.mem_addr_lo[0])
              || (wb.mem_funct3 == 3'd2 && wb.mem_addr_lo != 2'd0);
  end
  assign wb.mem_ready = rst_sync && stall_n && state_q == IDLE;
  assign wb.reg_waddr = reg_waddr_q;
  assign wb.reg_wdata = reg_wdata_q;
  assign wb.reg_wen   = reg_wen_q;
  assign wb.load_err  = load_err_q;
  assign wb.instret   = instret_q;
  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      f3_q        <= '0;
      lo_q        <= '0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      reg_wen_q   <= 1'b0;
      load_err_q  <= 1'b0;
      instret_q   <= '0;
    end else if (stall_n) begin
      reg_wen_q  <= 1'b0;
      load_err_q <= 1'b0;
      if (state_q == IDLE && wb.mem_valid) begin
        if (!wb.mem_is_load) begin
          reg_waddr_q <= wb.mem_rd_addr;
          reg_wdata_q <= wb.mem_result;
          reg_wen_q   <= wb.mem_rd_wen && wb.mem_rd_addr != 5'd0;
          instret_q   <= instret_q + 1'b1;
        end else if (bad_load_d) begin
          load_err_q <= 1'b1;
        end else begin
          rd_q    <= wb.mem_rd_addr;
          f3_q    <= wb.mem_funct3;
          lo_q    <= wb.mem_addr_lo;
          state_q <= WAIT_LOAD;
        end
      end else if (state_q == WAIT_LOAD && wb.dmem_rvalid) begin
        reg_waddr_q <= rd_q;
        reg_wdata_q <= ld_data_d;
        reg_wen_q   <= rd_q != 5'd0;
        instret_q   <= instret_q + 1'b1;
        state_q     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_core_wb_stage.sv
// tb_core_wb_stage: directed tests of the writeback stage with hand-computed expectations
module tb_core_wb_stage;
  localparam int XLEN = 32;
  localparam int RC   = 8;
  logic clk = 1'b0;
  logic rst_sync = 1'b1;
  logic stall_n = 1'b1;
  logic [RC-1:0] exp_ret = '0;
  int n_checks = 0;
  int n_fail = 0;
  core_wb_stage_if #(.XLEN(XLEN), .RET_CNT_W(RC)) wb ();
  core_wb_stage #(.XLEN(XLEN), .RET_CNT_W(RC)) dut (
    .clk(clk), .rst_sync(rst_sync), .stall_n(stall_n), .wb(wb)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    wb.mem_valid = 0; wb.mem_rd_addr = 0; wb.mem_rd_wen = 0; wb.mem_is_load = 0;
    wb.mem_funct3 = 0; wb.mem_addr_lo = 0; wb.mem_result = 0;
    wb.dmem_rvalid = 0; wb.dmem_rdata = 0;
  endtask
  task automatic send_alu(input logic [4:0] rd, input logic wen, input logic [XLEN-1:0] res);
    wb.mem_valid = 1; wb.mem_is_load = 0; wb.mem_rd_addr = rd; wb.mem_rd_wen = wen; wb.mem_result = res;
  endtask
  task automatic send_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    wb.mem_valid = 1; wb.mem_is_load = 1; wb.mem_rd_addr = rd; wb.mem_rd_wen = 1;
    wb.mem_funct3 = f3; wb.mem_addr_lo = lo;
  endtask
  task automatic test_reset();
    idle_inputs();
    #2 rst_sync = 0;
    #1;
    n_checks++;
    if ({wb.reg_wen, wb.load_err, wb.mem_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got wen/err/ready=%b expected 000", {wb.reg_wen, wb.load_err, wb.mem_ready});
    end
    n_checks++;
    if ({wb.reg_waddr, wb.reg_wdata, wb.instret} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got waddr=%h wdata=%h instret=%h expected all 0", wb.reg_waddr, wb.reg_wdata, wb.instret);
    end
    tick(); tick();
    rst_sync = 1;
    #1;
    n_checks++;
    if (wb.mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b expected 1", wb.mem_ready);
    end
  endtask
  task automatic test_alu_stream();
    logic [4:0]      rds [3] = '{5'd5, 5'd6, 5'd7};
    logic [XLEN-1:0] res [3] = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      send_alu(rds[i], 1'b1, res[i]);
      tick();
      exp_ret++;
      n_checks++;
      if ({wb.reg_wen, wb.reg_waddr, wb.reg_wdata} !== {1'b1, rds[i], res[i]}) begin
        n_fail++; $display("FAIL alu_write%0d: got wen=%b waddr=%0d wdata=%h expected 1 %0d %h", i, wb.reg_wen, wb.reg_waddr, wb.reg_wdata, rds[i], res[i]);
      end
    end
    idle_inputs();
    tick();
    n_checks++;
    if ({wb.reg_wen, wb.reg_waddr, wb.reg_wdata} !== {1'b0, 5'd7, 32'h33}) begin
      n_fail++; $display("FAIL alu_idle_hold: got wen=%b waddr=%0d wdata=%h expected 0 7 00000033", wb.reg_wen, wb.reg_waddr, wb.reg_wdata);
    end
    n_checks++;
    if (wb.instret !== 8'd3) begin
      n_fail++; $display("FAIL alu_instret: got %0d expected 3", wb.instret);
    end
  endtask
  task automatic test_x0_write();
    send_alu(5'd0, 1'b1, 32'hDEADBEEF);
    tick();
    exp_ret++;
    idle_inputs();
    n_checks++;
    if (wb.reg_wen !== 1'b0 || wb.instret !== exp_ret) begin
      n_fail++; $display("FAIL x0_write: got wen=%b instret=%0d expected 0 %0d", wb.reg_wen, wb.instret, exp_ret);
    end
  endtask
  task automatic test_loads();
    logic [2:0]      f3s [5] = '{3'd0, 3'd5, 3'd1, 3'd4, 3'd0};
    logic [1:0]      los [5] = '{2'd3, 2'd2, 2'd0, 2'd3, 2'd1};
    logic [XLEN-1:0] exps[5] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'h0000_1234, 32'h0000_0080, 32'h0000_0012};
    for (int i = 0; i < 5; i++) begin
      send_load(5'd10 + 5'(i), f3s[i], los[i]);
      tick();
      idle_inputs();
      tick();
      n_checks++;
      if (wb.mem_ready !== 1'b0 || wb.reg_wen !== 1'b0) begin
        n_fail++; $display("FAIL load_wait%0d: got ready=%b wen=%b expected 0 0", i, wb.mem_ready, wb.reg_wen);
      end
      wb.dmem_rvalid = 1; wb.dmem_rdata = 32'h80FF_1234;
      tick();
      exp_ret++;
      idle_inputs();
      n_checks++;
      if ({wb.reg_wen, wb.reg_waddr, wb.reg_wdata} !== {1'b1, 5'd10 + 5'(i), exps[i]}) begin
        n_fail++; $display("FAIL load_data%0d: got wen=%b waddr=%0d wdata=%h expected 1 %0d %h", i, wb.reg_wen, wb.reg_waddr, wb.reg_wdata, 10 + i, exps[i]);
      end
      n_checks++;
      if (wb.instret !== exp_ret || wb.mem_ready !== 1'b1) begin
        n_fail++; $display("FAIL load_done%0d: got instret=%0d ready=%b expected %0d 1", i, wb.instret, wb.mem_ready, exp_ret);
      end
    end
  endtask
  task automatic test_load_err();
    logic [2:0] f3s [4] = '{3'd2, 3'd3, 3'd5, 3'd7};
    logic [1:0] los [4] = '{2'd1, 2'd0, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      send_load(5'd20, f3s[i], los[i]);
      tick();
      idle_inputs();
      n_checks++;
      if ({wb.load_err, wb.reg_wen, wb.mem_ready} !== 3'b101 || wb.instret !== exp_ret) begin
        n_fail++; $display("FAIL load_err%0d: got err/wen/ready=%b instret=%0d expected 101 %0d", i, {wb.load_err, wb.reg_wen, wb.mem_ready}, wb.instret, exp_ret);
      end
      wb.dmem_rvalid = 1;
      tick();
      wb.dmem_rvalid = 0;
      n_checks++;
      if (wb.load_err !== 1'b0 || wb.reg_wen !== 1'b0) begin
        n_fail++; $display("FAIL load_err_pulse%0d: got err=%b wen=%b expected 0 0", i, wb.load_err, wb.reg_wen);
      end
    end
  endtask
  task automatic test_stall();
    send_alu(5'd9, 1'b1, 32'h55);
    tick();
    exp_ret++;
    stall_n = 0;
    send_alu(5'd12, 1'b1, 32'h99);
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (wb.mem_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_ready%0d: got %b expected 0", i, wb.mem_ready);
      end
      tick();
      n_checks++;
      if ({wb.reg_wen, wb.reg_waddr, wb.reg_wdata} !== {1'b1, 5'd9, 32'h55} || wb.instret !== exp_ret) begin
        n_fail++; $display("FAIL stall_hold%0d: got wen=%b waddr=%0d wdata=%h instret=%0d expected 1 9 00000055 %0d", i, wb.reg_wen, wb.reg_waddr, wb.reg_wdata, wb.instret, exp_ret);
      end
    end
    stall_n = 1;
    idle_inputs();
    tick();
    n_checks++;
    if (wb.reg_wen !== 1'b0 || wb.instret !== exp_ret || wb.reg_wdata !== 32'h55) begin
      n_fail++; $display("FAIL stall_release: got wen=%b instret=%0d wdata=%h expected 0 %0d 00000055", wb.reg_wen, wb.instret, wb.reg_wdata, exp_ret);
    end
  endtask
  task automatic test_stall_rvalid();
    send_load(5'd11, 3'd2, 2'd0);
    tick();
    idle_inputs();
    stall_n = 0;
    wb.dmem_rvalid = 1; wb.dmem_rdata = 32'hA5A5_A5A5;
    tick();
    n_checks++;
    if (wb.reg_wen !== 1'b0 || wb.instret !== exp_ret) begin
      n_fail++; $display("FAIL stall_rvalid_drop: got wen=%b instret=%0d expected 0 %0d", wb.reg_wen, wb.instret, exp_ret);
    end
    stall_n = 1;
    wb.dmem_rdata = 32'hCAFE_F00D;
    tick();
    exp_ret++;
    idle_inputs();
    n_checks++;
    if ({wb.reg_wen, wb.reg_waddr, wb.reg_wdata} !== {1'b1, 5'd11, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL stall_rvalid_replay: got wen=%b waddr=%0d wdata=%h expected 1 11 cafef00d", wb.reg_wen, wb.reg_waddr, wb.reg_wdata);
    end
  endtask
  task automatic test_idle_rvalid();
    wb.dmem_rvalid = 1; wb.dmem_rdata = 32'h1234_5678;
    tick();
    idle_inputs();
    n_checks++;
    if (wb.reg_wen !== 1'b0 || wb.instret !== exp_ret || wb.mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL idle_rvalid: got wen=%b instret=%0d ready=%b expected 0 %0d 1", wb.reg_wen, wb.instret, wb.mem_ready, exp_ret);
    end
  endtask
  task automatic test_back_to_back();
    int cyc = 0;
    while (exp_ret != '1 && cyc < 600) begin
      send_alu(5'd1 + 5'(cyc % 31), cyc[0], 32'(cyc));
      tick();
      exp_ret++;
      cyc++;
    end
    n_checks++;
    if (wb.instret !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_full: got instret=%h expected ff", wb.instret);
    end
    send_alu(5'd3, 1'b0, 32'h77);
    tick();
    exp_ret++;
    idle_inputs();
    n_checks++;
    if (wb.instret !== 8'h00 || wb.reg_wen !== 1'b0) begin
      n_fail++; $display("FAIL b2b_wrap: got instret=%h wen=%b expected 00 0", wb.instret, wb.reg_wen);
    end
  endtask
  task automatic test_reset_in_wait();
    send_load(5'd13, 3'd2, 2'd0);
    tick();
    idle_inputs();
    rst_sync = 0;
    #1;
    n_checks++;
    if ({wb.reg_wen, wb.load_err, wb.mem_ready, wb.reg_waddr, wb.reg_wdata, wb.instret} !== '0) begin
      n_fail++; $display("FAIL rst_wait_async: got wen=%b err=%b ready=%b waddr=%0d wdata=%h instret=%0d expected all 0", wb.reg_wen, wb.load_err, wb.mem_ready, wb.reg_waddr, wb.reg_wdata, wb.instret);
    end
    tick();
    rst_sync = 1;
    wb.dmem_rvalid = 1; wb.dmem_rdata = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    n_checks++;
    if ({wb.reg_wen, wb.reg_waddr, wb.reg_wdata, wb.instret} !== '0 || wb.mem_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_abandon: got wen=%b waddr=%0d wdata=%h instret=%0d ready=%b expected 0 0 0 0 1", wb.reg_wen, wb.reg_waddr, wb.reg_wdata, wb.instret, wb.mem_ready);
    end
  endtask
  initial begin
    test_reset();
    test_alu_stream();
    test_x0_write();
    test_loads();
    test_load_err();
    test_stall();
    test_stall_rvalid();
    test_idle_rvalid();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
